fetch_unit: RTL and testbench

Instruction fetch and PC sequencing stage that sits directly upstream of the control decoder. It owns the program counter and fetches 16-bit RiSC-16 instruction words over a req/ack instruction-memory handshake. It holds the current instruction on ir together with its pc for the decoder. It consumes the decoder's 2-bit branch code, the BEQ equality result and the JALR target to compute the next PC. A fetch timeout counter latches a fault and halts the stage.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RiSC-16 program counter and instruction fetch over a req/ack imem port.
// Holds ir/pc for the decoder, retires on exec_ready and latches a sticky fetch-timeout fault.
`default_nettype none

module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic [15:0] pc,
    output logic        ir_valid,
    input  logic [1:0]  branch,
    input  logic        beq_equal,
    input  logic [15:0] jalr_target,
    input  logic        exec_ready,
    output logic        fault
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [15:0] pc_inc;
    logic [15:0] beq_off;
    logic [15:0] next_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ir_q    <= 16'h0000;
            cnt_q   <= 16'h0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Branch target arithmetic wraps naturally at 16 bits.
    always_comb begin
        pc_inc  = pc_q + 16'd1;
        beq_off = {{9{ir_q[6]}}, ir_q[6:0]};
        case (branch)
            2'b10:   next_pc = beq_equal ? (pc_inc + beq_off) : pc_inc;
            2'b01:   next_pc = jalr_target;
            default: next_pc = pc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = valid_q;
        fault_d = fault_q;

        case (state_q)
            S_REQ: begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                cnt_d   = 16'h0000;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the timeout edge takes priority over the fault.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    cnt_d   = 16'h0000;
                    state_d = S_EXEC;
                end else if (cnt_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXEC: begin
                if (exec_ready) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign ir_valid  = valid_q;
    assign fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetch/retire vectors plus timeout and async-reset sequences.
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        ir_valid;
    logic [1:0]  branch = 2'b00;
    logic        beq_equal = 1'b0;
    logic [15:0] jalr_target = 16'h0000;
    logic        exec_ready = 1'b0;
    logic        fault;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC      (16'h0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .pc         (pc),
        .ir_valid   (ir_valid),
        .branch     (branch),
        .beq_equal  (beq_equal),
        .jalr_target(jalr_target),
        .exec_ready (exec_ready),
        .fault      (fault)
    );

    typedef struct {
        logic [15:0] addr;   // expected fetch address (and pc during EXEC)
        logic [15:0] rdata;  // instruction returned
        int          wt;     // WAIT edges without ack before the acking edge
        int          ex;     // extra EXEC stall cycles
        logic [1:0]  br;
        logic        eq;
        logic [15:0] jt;
        logic [15:0] nxt;    // expected next fetch address
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) @(negedge clk);
        chk("req_seen", {15'd0, imem_req}, 16'h0001);
    endtask

    task automatic run_vec(input vec_t v);
        wait_req();
        chk("fetch_addr", imem_addr, v.addr);
        chk("valid_in_wait", {15'd0, ir_valid}, 16'h0000);
        imem_ack   = 1'b0;
        exec_ready = 1'b1;
        repeat (v.wt) @(negedge clk);
        chk("addr_stable", imem_addr, v.addr);
        exec_ready = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        chk("ir_loaded", ir, v.rdata);
        chk("pc_exec", pc, v.addr);
        chk("valid_exec", {15'd0, ir_valid}, 16'h0001);
        chk("req_drop", {15'd0, imem_req}, 16'h0000);
        chk("no_fault", {15'd0, fault}, 16'h0000);
        imem_rdata  = ~v.rdata;
        branch      = ~v.br;
        jalr_target = 16'hDEAD;
        repeat (v.ex) @(negedge clk);
        chk("ir_hold", ir, v.rdata);
        chk("pc_hold", pc, v.addr);
        imem_ack    = 1'b0;
        exec_ready  = 1'b1;
        branch      = v.br;
        beq_equal   = v.eq;
        jalr_target = v.jt;
        @(negedge clk);
        exec_ready  = 1'b0;
        branch      = 2'b01;
        jalr_target = 16'hBEEF;
        chk("valid_retire", {15'd0, ir_valid}, 16'h0000);
        chk("req_gap", {15'd0, imem_req}, 16'h0000);
        @(negedge clk);
        chk("req_next", {15'd0, imem_req}, 16'h0001);
        chk("next_addr", imem_addr, v.nxt);
        n_vec++;
    endtask

    initial begin
        vt[0]  = '{16'h0000, 16'h2481, 2, 0, 2'b00, 1'b0, 16'hFFFF, 16'h0001};
        vt[1]  = '{16'h0001, 16'h0000, 0, 0, 2'b01, 1'b0, 16'h0010, 16'h0010};
        vt[2]  = '{16'h0010, 16'h807C, 0, 1, 2'b10, 1'b1, 16'hAAAA, 16'h000D};
        vt[3]  = '{16'h000D, 16'h8000, 1, 0, 2'b01, 1'b0, 16'h0010, 16'h0010};
        vt[4]  = '{16'h0010, 16'h807C, 0, 0, 2'b10, 1'b0, 16'h5555, 16'h0011};
        vt[5]  = '{16'h0011, 16'h0000, 3, 0, 2'b01, 1'b0, 16'h0040, 16'h0040};
        vt[6]  = '{16'h0040, 16'hE000, 0, 3, 2'b01, 1'b0, 16'h1234, 16'h1234};
        vt[7]  = '{16'h1234, 16'h0000, 0, 0, 2'b01, 1'b0, 16'hFFFF, 16'hFFFF};
        vt[8]  = '{16'hFFFF, 16'h0000, 0, 0, 2'b00, 1'b1, 16'h0000, 16'h0000};
        vt[9]  = '{16'h0000, 16'h8040, 0, 0, 2'b10, 1'b1, 16'h0000, 16'hFFC1};
        vt[10] = '{16'hFFC1, 16'h807F, 0, 0, 2'b10, 1'b1, 16'h0000, 16'hFFC1};
        vt[11] = '{16'hFFC1, 16'h0000, 0, 0, 2'b11, 1'b1, 16'h1234, 16'hFFC2};
        vt[12] = '{16'hFFC2, 16'hC07F, 1, 0, 2'b10, 1'b0, 16'h0000, 16'hFFC3};

        repeat (3) @(negedge clk);
        chk("rst_req", {15'd0, imem_req}, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'd0, ir_valid}, 16'h0000);
        chk("rst_fault", {15'd0, fault}, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk("first_req", {15'd0, imem_req}, 16'h0001);

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        // Timeout: next fetch at FFC3 is never acknowledged.
        chk("tmo_addr", imem_addr, 16'hFFC3);
        repeat (3) @(negedge clk);
        chk("tmo_pre_fault", {15'd0, fault}, 16'h0000);
        chk("tmo_pre_req", {15'd0, imem_req}, 16'h0001);
        @(negedge clk);
        chk("tmo_fault", {15'd0, fault}, 16'h0001);
        chk("tmo_req_off", {15'd0, imem_req}, 16'h0000);
        imem_ack   = 1'b1;
        exec_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("halt_fault", {15'd0, fault}, 16'h0001);
        chk("halt_req", {15'd0, imem_req}, 16'h0000);
        chk("halt_valid", {15'd0, ir_valid}, 16'h0000);
        imem_ack   = 1'b0;
        exec_ready = 1'b0;
        #2 rst = 1'b0;
        #1 chk("halt_rst_fault", {15'd0, fault}, 16'h0000);
        n_vec++;
        @(negedge clk);
        rst = 1'b1;

        // Reset during WAIT.
        wait_req();
        chk("w_addr", imem_addr, 16'h0000);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("w_rst_req", {15'd0, imem_req}, 16'h0000);
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        @(negedge clk);
        chk("w_rst_ir", ir, 16'h0000);
        imem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("w_refetch_req", {15'd0, imem_req}, 16'h0001);
        chk("w_refetch_addr", imem_addr, 16'h0000);
        n_vec++;

        // Reset during EXEC.
        imem_ack   = 1'b1;
        imem_rdata = 16'h1357;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("e_ir", ir, 16'h1357);
        chk("e_valid", {15'd0, ir_valid}, 16'h0001);
        #2 rst = 1'b0;
        #1 chk("e_rst_valid", {15'd0, ir_valid}, 16'h0000);
        chk("e_rst_ir", ir, 16'h0000);
        chk("e_rst_pc", pc, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("e_refetch_req", {15'd0, imem_req}, 16'h0001);
        chk("e_refetch_addr", imem_addr, 16'h0000);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
